led_module: RTL and testbench
=============================

# led_module

Autonomous status-LED driver: a clock prescaler produces a slow tick, a tick-indexed sequencer steps through a fixed on/off pattern, and an optional PWM stage dims the lit phases. It has no control inputs; behaviour is fixed by parameters at elaboration. It sits at the board top level and drives one LED pin directly from a register, so the output is glitch-free.

## Interface
- `TICK_DIV`, default 4: clock cycles per pattern step; legal range is ≥1.
- `PAT_LEN`, default 16: pattern length in steps; legal range is 1..32.
- `PATTERN`, default 32'h0000_00FF: on/off sequence. Bit i is step i, starting from the LSB. Only bits [PAT_LEN-1:0] are used.
- `PWM_BITS`, default 2: width of the PWM counter; legal range is ≥1.
- `DUTY`, default 4: lit fraction is DUTY/2^PWM_BITS. The legal range is 0..2^PWM_BITS. 0 means always dark; 2^PWM_BITS means fully on.
- `clk`, input, 1 bit: the single clock. All state updates on its rising edge.
- `rst`, input, 1 bit: asynchronous, active-low reset. Asserting it (0) clears all state immediately. Release is synchronous to `clk`.
- `led`, output, 1 bit: registered LED drive, 1 = lit.

## Operation
- **Reset (`rst`=0):** `div_cnt`=0, `idx`=0, `pwm_cnt`=0, `led`=0. These values hold for as long as `rst` is low, regardless of clock activity.
- **Prescaler:** `div_cnt` counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` = (`div_cnt` == TICK_DIV-1). It is combinational and lasts one cycle.
  - With TICK_DIV=1, `tick` is asserted every cycle.
- **Sequencer:** on each `tick`, `idx` advances by one and wraps from PAT_LEN-1 to 0.
- **PWM:** `pwm_cnt` free-runs modulo 2^PWM_BITS every cycle. It is independent of `tick`.
- **Output:** `led` <= PATTERN[`idx`] & (`pwm_cnt` < DUTY). The comparison is unsigned and one bit wider than PWM_BITS, so that DUTY=2^PWM_BITS is always true.
- **Illegal parameters:** out-of-range values are rejected at elaboration (TICK_DIV=0, PAT_LEN=0, PAT_LEN>32, DUTY>2^PWM_BITS).

## Timing
- Edge 1 is the first rising edge of `clk` after `rst` goes high. After edge k (k≥1):
  - `div_cnt` = k mod TICK_DIV
  - `idx` = floor(k/TICK_DIV) mod PAT_LEN
  - `pwm_cnt` = k mod 2^PWM_BITS
- **Output latency:** one cycle. `led` after edge k is computed from the `idx` and `pwm_cnt` values held after edge k-1, with state before edge 1 equal to the reset values. With full duty this gives `led` = PATTERN[floor((k-1)/TICK_DIV) mod PAT_LEN].
- **Pattern period:** TICK_DIV×PAT_LEN cycles. The pattern wrap is seamless, with no gap cycle.
- **Reset mid-operation:** `led` drops to 0 asynchronously, without waiting for a clock edge. The sequence restarts from step 0 after release.
- A `tick` and a `pwm_cnt` wrap in the same cycle need no special handling; the two counters are independent.

## Structure
- **Shared package `led_pkg`:**
  - constant `LED_PAT_MAX` = 32
  - function `clog2` for counter widths
  - defaults for the pattern and duty parameters
- **Sub-module `led_tick_gen`:** prescaler with parameter TICK_DIV, ports `clk`, `rst`, output `tick`. It is reused elsewhere for slow strobes.
- **Top level:** holds the sequencer, the PWM counter, and the output register.

## Test plan
- **Held in reset:** `rst`=0 for 7 clock edges (period 10) -> `led`=0 throughout, with no X after time 0.
- **Default parameters:** release reset, then run 64 edges -> `led`=1 for edges 1..32 and 0 for edges 33..64; from edge 65 the pattern repeats identically.
- **Asynchronous reset:** assert `rst` low between edges at edge 10 -> `led` goes 0 immediately, before the next edge. After release, `led`=1 at new edge 1, and `idx` has restarted.
- **Single-cycle ticks:** TICK_DIV=1, PAT_LEN=4, PATTERN=4'b0110 -> `led` sequence from edge 1 is 0,1,1,0,0,1,1,0.
- **PWM dimming:** TICK_DIV=4, PATTERN all ones, PWM_BITS=2, DUTY=1 -> `led`=1 only after edges 1, 5, 9, ... (i.e. k≡1 mod 4). With DUTY=0, `led` is always 0.
- **Sampled check:** a randomized-reset scoreboard compares `led` against the closed-form Timing formula for 1000 cycles, using TICK_DIV=3 and PAT_LEN=5.

Source files
------------

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared constants and helpers for the status-LED driver.
//   LED_PAT_MAX      : widest pattern the sequencer can index (bits)
//   LED_*_DEF        : default parameter values used by led_module
//   clog2()          : counter width helper, never returns less than 1 bit
// ---------------------------------------------------------------------------
package led_pkg;

   localparam int                   LED_PAT_MAX      = 32;

   localparam int                   LED_TICK_DIV_DEF = 4;
   localparam int                   LED_PAT_LEN_DEF  = 16;
   localparam logic [LED_PAT_MAX-1:0] LED_PATTERN_DEF = 32'h0000_00FF;
   localparam int                   LED_PWM_BITS_DEF = 2;
   localparam int                   LED_DUTY_DEF     = 4;

   // Width needed to count 0..value-1. A counter that only ever holds 0
   // still gets one bit so that every vector has a legal range.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) begin
         width++;
      end
      return width;
   endfunction

endpackage

// File: rtl/led_if.sv
// ---------------------------------------------------------------------------
// led_if
// Carries the LED drive from the driver to the board pin.
//   led    : 1 = lit
// Modports:
//   master : driver side (led_module), drives led
//   slave  : pin / observer side, reads led
// ---------------------------------------------------------------------------
interface led_if;

   logic led;

   modport master (output led);
   modport slave  (input  led);

endinterface

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen
// Clock prescaler: a counter running 0..TICK_DIV-1 that emits a one-cycle
// strobe on its last count. Also used elsewhere for slow strobes.
// Parameters:
//   TICK_DIV : clock cycles per strobe, >= 1 (1 = strobe every cycle)
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   tick : combinational strobe, high while the counter sits at TICK_DIV-1
// ---------------------------------------------------------------------------
module led_tick_gen
   import led_pkg::*;
#(
   parameter int TICK_DIV = LED_TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   generate
      if (TICK_DIV < 1) begin : g_bad_div
         $error("led_tick_gen: TICK_DIV must be at least 1");
      end
   endgenerate

   localparam int                CNT_W    = clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_div_cnt;

   // With TICK_DIV=1 CNT_LAST is 0, so the counter stays at 0 and the
   // strobe is held high every cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div_cnt <= '0;
      end else if (r_div_cnt == CNT_LAST) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + CNT_W'(1);
      end
   end

   assign tick = (r_div_cnt == CNT_LAST);

endmodule

// File: rtl/led_module.sv
// ---------------------------------------------------------------------------
// led_module
// Autonomous status-LED driver. A prescaler strobe steps an index through a
// fixed on/off pattern; a free-running PWM counter dims the lit steps. The
// pin is driven straight from a flop so it never glitches.
// Parameters:
//   TICK_DIV : clock cycles per pattern step, >= 1
//   PAT_LEN  : pattern length in steps, 1..LED_PAT_MAX
//   PATTERN  : bit i is the on/off value of step i (LSB first)
//   PWM_BITS : PWM counter width, >= 1
//   DUTY     : lit fraction DUTY/2^PWM_BITS, 0..2^PWM_BITS
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset, release synchronous to clk
//   led  : led_if master, registered LED drive (1 = lit)
// ---------------------------------------------------------------------------
module led_module
   import led_pkg::*;
#(
   parameter int                     TICK_DIV = LED_TICK_DIV_DEF,
   parameter int                     PAT_LEN  = LED_PAT_LEN_DEF,
   parameter logic [LED_PAT_MAX-1:0] PATTERN  = LED_PATTERN_DEF,
   parameter int                     PWM_BITS = LED_PWM_BITS_DEF,
   parameter int                     DUTY     = LED_DUTY_DEF
) (
   input  logic     clk,
   input  logic     rst,
   led_if.master    led
);

   // Reject out-of-range parameters while elaborating.
   generate
      if (PAT_LEN < 1 || PAT_LEN > LED_PAT_MAX) begin : g_bad_len
         $error("led_module: PAT_LEN must be in 1..%0d", LED_PAT_MAX);
      end
      if (PWM_BITS < 1) begin : g_bad_pwm
         $error("led_module: PWM_BITS must be at least 1");
      end
      if (DUTY < 0 || DUTY > (1 << PWM_BITS)) begin : g_bad_duty
         $error("led_module: DUTY must be in 0..2^PWM_BITS");
      end
   endgenerate

   localparam int                  IDX_W    = clog2(PAT_LEN);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(PAT_LEN - 1);
   // One bit wider than the PWM counter so that DUTY=2^PWM_BITS compares
   // true for every counter value (fully on).
   localparam logic [PWM_BITS:0]   DUTY_CMP = (PWM_BITS + 1)'(DUTY);

   logic                 w_tick;
   logic [IDX_W-1:0]     r_idx;
   logic [PWM_BITS-1:0]  r_pwm_cnt;
   logic                 r_led;
   logic                 w_pat_bit;
   logic                 w_pwm_on;

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Sequencer: one step per prescaler strobe, seamless wrap to step 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx <= '0;
      end else if (w_tick) begin
         if (r_idx == IDX_LAST) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

   // PWM counter free-runs every cycle, unrelated to the step strobe;
   // natural binary overflow gives the modulo-2^PWM_BITS wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end
   end

   assign w_pat_bit = PATTERN[r_idx];
   assign w_pwm_on  = ({1'b0, r_pwm_cnt} < DUTY_CMP);

   // Output flop: one cycle behind idx/pwm_cnt, cleared immediately by rst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_led <= 1'b0;
      end else begin
         r_led <= w_pat_bit & w_pwm_on;
      end
   end

   assign led.led = r_led;

endmodule

// File: tb/tb_led_module.sv
// ---------------------------------------------------------------------------
// tb_led_module
// Self-checking bench for led_module. Five instances with different
// parameter sets share one clock and reset; each scenario task pushes the
// expected LED value for the coming edge onto a scoreboard queue and pops
// and compares it on the following falling edge.
//   u0 : defaults (TICK_DIV=4, PAT_LEN=16, PATTERN=0xFF, full duty)
//   u1 : TICK_DIV=1, PAT_LEN=4, PATTERN=4'b0110
//   u2 : TICK_DIV=4, all-ones pattern, PWM_BITS=2, DUTY=1
//   u3 : same as u2 with DUTY=0
//   u4 : TICK_DIV=3, PAT_LEN=5, PATTERN=5'b10110, PWM_BITS=2, DUTY=3
// ---------------------------------------------------------------------------
module tb_led_module;

   typedef struct {
      int    id;
      int    kidx;
      logic  exp;
      string tag;
   } sb_t;

   localparam logic [31:0] P4     = 32'h0000_0016;
   localparam int          TD4    = 3;
   localparam int          PL4    = 5;
   localparam int          DUTY4  = 3;

   logic clk;
   logic rst;

   sb_t  sb[$];
   int   n_cmp;
   int   n_bad;

   led_if if0 ();
   led_if if1 ();
   led_if if2 ();
   led_if if3 ();
   led_if if4 ();

   led_module u0 (
      .clk (clk),
      .rst (rst),
      .led (if0)
   );

   led_module #(
      .TICK_DIV (1),
      .PAT_LEN  (4),
      .PATTERN  (32'h0000_0006),
      .PWM_BITS (2),
      .DUTY     (4)
   ) u1 (
      .clk (clk),
      .rst (rst),
      .led (if1)
   );

   led_module #(
      .TICK_DIV (4),
      .PAT_LEN  (16),
      .PATTERN  (32'hFFFF_FFFF),
      .PWM_BITS (2),
      .DUTY     (1)
   ) u2 (
      .clk (clk),
      .rst (rst),
      .led (if2)
   );

   led_module #(
      .TICK_DIV (4),
      .PAT_LEN  (16),
      .PATTERN  (32'hFFFF_FFFF),
      .PWM_BITS (2),
      .DUTY     (0)
   ) u3 (
      .clk (clk),
      .rst (rst),
      .led (if3)
   );

   led_module #(
      .TICK_DIV (TD4),
      .PAT_LEN  (PL4),
      .PATTERN  (P4),
      .PWM_BITS (2),
      .DUTY     (DUTY4)
   ) u4 (
      .clk (clk),
      .rst (rst),
      .led (if4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic act(input int id);
      case (id)
         0:       return if0.led;
         1:       return if1.led;
         2:       return if2.led;
         3:       return if3.led;
         default: return if4.led;
      endcase
   endfunction

   // Closed-form value for u4 after edge k (k=0 means still in reset).
   function automatic logic model4(input int k);
      logic [31:0] pat;
      int          step;
      int          pwm;
      if (k == 0) return 1'b0;
      pat  = P4;
      step = ((k - 1) / TD4) % PL4;
      pwm  = (k - 1) % 4;
      return pat[step] & (pwm < DUTY4);
   endfunction

   // Pulse reset for two edges; returns on the falling edge where rst is
   // released, so the next rising edge is edge 1.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      sb_t e;
      logic got;
      for (int c = 0; c < 7; c++) begin
         for (int id = 0; id < 5; id++) sb.push_back('{id, 0, 1'b0, "reset_hold"});
         @(posedge clk);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = act(e.id);
            n_cmp++;
            if (got !== e.exp) begin
               n_bad++;
               $display("FAIL %s u%0d edge %0d: led=%b expected %b", e.tag, e.id, e.kidx, got, e.exp);
            end
         end
      end
   endtask

   task automatic test_default();
      sb_t e;
      logic got;
      do_reset();
      for (int k = 1; k <= 96; k++) begin
         sb.push_back('{0, k, (((k - 1) % 64) < 32), "default"});
         @(posedge clk);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = act(e.id);
            n_cmp++;
            if (got !== e.exp) begin
               n_bad++;
               $display("FAIL %s u%0d edge %0d: led=%b expected %b", e.tag, e.id, e.kidx, got, e.exp);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      sb_t e;
      logic got;
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         sb.push_back('{0, k, (((k - 1) % 64) < 32), "async_pre"});
         @(posedge clk);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = act(e.id);
            n_cmp++;
            if (got !== e.exp) begin
               n_bad++;
               $display("FAIL %s u%0d edge %0d: led=%b expected %b", e.tag, e.id, e.kidx, got, e.exp);
            end
         end
      end
      // Between edge 10 and 11: drop reset, the LED must clear before any edge.
      rst = 1'b0;
      #1;
      sb.push_back('{0, 10, 1'b0, "async_drop"});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         got = act(e.id);
         n_cmp++;
         if (got !== e.exp) begin
            n_bad++;
            $display("FAIL %s u%0d edge %0d: led=%b expected %b", e.tag, e.id, e.kidx, got, e.exp);
         end
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         sb.push_back('{0, k, (((k - 1) % 64) < 32), "async_restart"});
         @(posedge clk);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = act(e.id);
            n_cmp++;
            if (got !== e.exp) begin
               n_bad++;
               $display("FAIL %s u%0d edge %0d: led=%b expected %b", e.tag, e.id, e.kidx, got, e.exp);
            end
         end
      end
   endtask

   task automatic test_single_tick();
      sb_t         e;
      logic        got;
      logic [3:0]  seq;
      seq = 4'b0110;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         sb.push_back('{1, k, seq[(k - 1) % 4], "single_tick"});
         @(posedge clk);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = act(e.id);
            n_cmp++;
            if (got !== e.exp) begin
               n_bad++;
               $display("FAIL %s u%0d edge %0d: led=%b expected %b", e.tag, e.id, e.kidx, got, e.exp);
            end
         end
      end
   endtask

   task automatic test_pwm();
      sb_t e;
      logic got;
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         sb.push_back('{2, k, ((k % 4) == 1), "pwm_duty1"});
         sb.push_back('{3, k, 1'b0, "pwm_duty0"});
         @(posedge clk);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = act(e.id);
            n_cmp++;
            if (got !== e.exp) begin
               n_bad++;
               $display("FAIL %s u%0d edge %0d: led=%b expected %b", e.tag, e.id, e.kidx, got, e.exp);
            end
         end
      end
   endtask

   task automatic test_random_reset();
      sb_t  e;
      logic got;
      int   k;
      logic hit;
      do_reset();
      k = 0;
      for (int c = 0; c < 1000; c++) begin
         hit = ($urandom_range(0, 39) == 0);
         if (hit) begin
            rst = 1'b0;
            k   = 0;
            sb.push_back('{4, k, 1'b0, "random_rst"});
         end else begin
            rst = 1'b1;
            k++;
            sb.push_back('{4, k, model4(k), "random_run"});
         end
         @(posedge clk);
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            got = act(e.id);
            n_cmp++;
            if (got !== e.exp) begin
               n_bad++;
               $display("FAIL %s u%0d edge %0d: led=%b expected %b", e.tag, e.id, e.kidx, got, e.exp);
            end
         end
      end
      rst = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b0;
      test_reset();
      test_default();
      test_async_reset();
      test_single_tick();
      test_pwm();
      test_random_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
